sync_event_filter: RTL

//   Sits directly downstream of the 2-flop signal synchronizer and consumes its

---
 rtl/sync_event_filter_if.sv | 29 ++
 rtl/sync_event_filter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sync_event_filter_if.sv
// Bundle of control inputs and filtered status outputs for sync_event_filter.
// dbg_state mirrors the filter FSM state for checkers and debug visibility.
interface sync_event_filter_if #(
    parameter int CNT_W = 8
);
    logic             a_sync;
    logic             en;
    logic             evt_cnt_clr;
    logic             irq_clr;
    logic             level;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] evt_cnt;
    logic             cnt_ovf;
    logic             irq;
    logic [1:0]       dbg_state;

    // Handshake: none. Inputs are levels/strobes sampled every rising clk edge;
    // outputs are registered and valid every cycle (pulses last exactly one cycle).
    modport master (
        output a_sync, en, evt_cnt_clr, irq_clr,
        input  level, rise_pulse, fall_pulse, evt_cnt, cnt_ovf, irq, dbg_state
    );

    modport slave (
        input  a_sync, en, evt_cnt_clr, irq_clr,
        output level, rise_pulse, fall_pulse, evt_cnt, cnt_ovf, irq, dbg_state
    );
endinterface

// File: rtl/sync_event_filter.sv
// Glitch filter for a synchronized level: debounces over STABLE_CYCLES samples,
// emits rise/fall pulses, counts accepted rises (saturating) and raises a sticky irq.
module sync_event_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_event_filter_if.slave  bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    state_t           state;
    logic [SW-1:0]    stab_cnt;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] evt_cnt_q;
    logic             cnt_ovf_q;
    logic             irq_q;

    logic             rise_acc;
    logic             fall_acc;

    // An edge is accepted on the cycle that samples the last required differing value.
    always_comb begin
        rise_acc = 1'b0;
        fall_acc = 1'b0;
        if (bus.en) begin
            if (bus.a_sync) begin
                rise_acc = ((state == STABLE_LO) && (STABLE_CYCLES == 1)) ||
                           ((state == PEND_HI) && (stab_cnt == STAB_LAST));
            end else begin
                fall_acc = ((state == STABLE_HI) && (STABLE_CYCLES == 1)) ||
                           ((state == PEND_LO) && (stab_cnt == STAB_LAST));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STABLE_LO;
            stab_cnt <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            rise_q <= rise_acc;
            fall_q <= fall_acc;
            if (rise_acc) begin
                level_q <= 1'b1;
            end else if (fall_acc) begin
                level_q <= 1'b0;
            end

            if (!bus.en) begin
                // Disabled: drop any pending progress, comparison restarts from frozen level.
                state    <= level_q ? STABLE_HI : STABLE_LO;
                stab_cnt <= '0;
            end else begin
                case (state)
                    STABLE_LO: begin
                        if (bus.a_sync) begin
                            if (rise_acc) begin
                                state <= STABLE_HI;
                            end else begin
                                state    <= PEND_HI;
                                stab_cnt <= SW'(1);
                            end
                        end
                    end
                    PEND_HI: begin
                        if (!bus.a_sync) begin
                            state    <= STABLE_LO;
                            stab_cnt <= '0;
                        end else if (rise_acc) begin
                            state    <= STABLE_HI;
                            stab_cnt <= '0;
                        end else begin
                            stab_cnt <= stab_cnt + 1'b1;
                        end
                    end
                    STABLE_HI: begin
                        if (!bus.a_sync) begin
                            if (fall_acc) begin
                                state <= STABLE_LO;
                            end else begin
                                state    <= PEND_LO;
                                stab_cnt <= SW'(1);
                            end
                        end
                    end
                    PEND_LO: begin
                        if (bus.a_sync) begin
                            state    <= STABLE_HI;
                            stab_cnt <= '0;
                        end else if (fall_acc) begin
                            state    <= STABLE_LO;
                            stab_cnt <= '0;
                        end else begin
                            stab_cnt <= stab_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= STABLE_LO;
                        stab_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // A clear coincident with a rise still records that rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt_q <= '0;
            cnt_ovf_q <= 1'b0;
        end else if (bus.evt_cnt_clr) begin
            evt_cnt_q <= rise_acc ? CNT_W'(1) : '0;
            cnt_ovf_q <= 1'b0;
        end else if (rise_acc) begin
            if (evt_cnt_q == CNT_MAX) begin
                cnt_ovf_q <= 1'b1;
            end else begin
                evt_cnt_q <= evt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (rise_acc || fall_acc) begin
            irq_q <= 1'b1;
        end else if (bus.irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign bus.level      = level_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.evt_cnt    = evt_cnt_q;
    assign bus.cnt_ovf    = cnt_ovf_q;
    assign bus.irq        = irq_q;
    assign bus.dbg_state  = state;
endmodule
